// File: rtl/axis_rr_packet_arbiter.sv
// Purpose: packet-locked round-robin arbiter sharing one AXI-Stream sink between NUM_PORTS sources.
// Latency: 1 cycle from request to first presented beat; datapath is combinational while locked.
// Backpressure: m_axis_tready is routed only to the granted source; no buffering, no dropped beats.
//
// Ports:
//   aclk, aresetn        clock and synchronous active-low reset
//   s_axis_*             packed per-port sources (port i at [i*TDATA_BITS +: TDATA_BITS])
//   m_axis_*             shared sink
//   port_en              per-port permission to win new grants (does not abort a locked packet)
//   grant_valid/grant_id currently held packet grant
//   pkt_count            count of completed packets (tlast handshakes), wraps at 2^32
module axis_rr_packet_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int TDATA_BITS = 32,
    parameter int ID_BITS    = 2
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [NUM_PORTS*TDATA_BITS-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    output logic [TDATA_BITS-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    input  logic [NUM_PORTS-1:0]            port_en,
    output logic                            grant_valid,
    output logic [ID_BITS-1:0]              grant_id,
    output logic [31:0]                     pkt_count
);

    // Per-port vectors are padded to the full grant_id code space so they can be
    // indexed directly by an ID_BITS-wide grant; the padding slots are tied off.
    localparam int NSLOT = 2 ** ID_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ID_BITS-1:0]  grant_id_q, grant_id_d;
    logic [ID_BITS-1:0]  last_grant_q, last_grant_d;
    logic [31:0]         pkt_count_q, pkt_count_d;

    logic [NSLOT-1:0]      req_ext;
    logic [NSLOT-1:0]      tvalid_ext;
    logic [NSLOT-1:0]      tlast_ext;
    logic [NSLOT-1:0]      tready_ext;
    logic [TDATA_BITS-1:0] port_dat [NSLOT];

    logic                  winner_found;
    logic [ID_BITS-1:0]    winner;
    logic [ID_BITS-1:0]    scan_idx;
    int                    scan_sum;
    logic                  lock;
    logic                  last_hs;

    assign req_ext    = NSLOT'(s_axis_tvalid & port_en);
    assign tvalid_ext = NSLOT'(s_axis_tvalid);
    assign tlast_ext  = NSLOT'(s_axis_tlast);

    for (genvar i = 0; i < NSLOT; i++) begin : g_unpack
        if (i < NUM_PORTS) begin : g_real
            assign port_dat[i] = s_axis_tdata[i*TDATA_BITS +: TDATA_BITS];
        end else begin : g_pad
            assign port_dat[i] = '0;
        end
    end

    // Rotating priority: scan last_grant+1, last_grant+2, ... modulo NUM_PORTS,
    // so the most recently served port is considered last.
    always_comb begin
        winner_found = 1'b0;
        winner       = '0;
        scan_sum     = 0;
        scan_idx     = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            scan_sum = int'(last_grant_q) + k;
            if (scan_sum >= NUM_PORTS) begin
                scan_sum = scan_sum - NUM_PORTS;
            end
            scan_idx = ID_BITS'(scan_sum);
            if (!winner_found && req_ext[scan_idx]) begin
                winner_found = 1'b1;
                winner       = scan_idx;
            end
        end
    end

    // Output mux follows the registered grant. In IDLE the mux still points at a
    // real port so tdata/tlast never go unknown, but tvalid and tready stay low.
    always_comb begin
        lock          = (state_q == LOCK);
        m_axis_tdata  = port_dat[grant_id_q];
        m_axis_tlast  = tlast_ext[grant_id_q];
        m_axis_tvalid = lock & tvalid_ext[grant_id_q];
        tready_ext    = '0;
        if (lock) begin
            tready_ext[grant_id_q] = m_axis_tready;
        end
        s_axis_tready = tready_ext[NUM_PORTS-1:0];
        last_hs       = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    end

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        pkt_count_d  = pkt_count_q;
        case (state_q)
            IDLE: begin
                if (winner_found) begin
                    state_d    = LOCK;
                    grant_id_d = winner;
                end
            end
            LOCK: begin
                // Release only on the tlast handshake; an IDLE cycle always follows.
                if (last_hs) begin
                    state_d      = IDLE;
                    last_grant_d = grant_id_q;
                    pkt_count_d  = pkt_count_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_grant_q <= ID_BITS'(NUM_PORTS - 1);
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign grant_valid = lock;
    assign grant_id    = grant_id_q;
    assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Purpose: randomized and directed stimulus for axis_rr_packet_arbiter against a packet-level model.
// Latency: model expects the grant one cycle after an eligible request and one IDLE cycle between packets.
// Backpressure: sink ready is constant, patterned or random; sources hold data until handshaken.
module tb_axis_rr_packet_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDB = 2;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic [N*W-1:0]   s_axis_tdata;
    logic [N-1:0]     s_axis_tvalid;
    logic [N-1:0]     s_axis_tlast;
    logic [N-1:0]     s_axis_tready;
    logic [W-1:0]     m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tlast;
    logic             m_axis_tready;
    logic [N-1:0]     port_en;
    logic             grant_valid;
    logic [IDB-1:0]   grant_id;
    logic [31:0]      pkt_count;

    always #5 aclk = ~aclk;

    axis_rr_packet_arbiter #(.NUM_PORTS(N), .TDATA_BITS(W), .ID_BITS(IDB)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .port_en       (port_en),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .pkt_count     (pkt_count)
    );

    int tests_run = 0;
    int tests_failed = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Per-port source storage: {tlast, tdata} beats between head and tail.
    logic [W:0] mem [N][256];
    int head [N];
    int tail [N];
    int vprob = 100;   // percent chance a source presents its next beat
    int rmode = 0;     // 0: sink always ready, 1: pattern 1,0,0, 2: random
    int cyc = 0;

    typedef struct {
        logic [W-1:0] dat;
        logic         last;
        int           port;
    } exp_t;
    exp_t sb[$];
    int dut_log[$];    // port of each completed packet as reported by grant_id
    int dut_beats = 0;
    int m_owner = -1;  // model: port holding the grant, -1 when idle

    task automatic push_pkt(input int p, input int len, input logic [W-1:0] base, input bit rnd);
        for (int b = 0; b < len; b++) begin
            logic [W-1:0] d;
            d = rnd ? W'($urandom) : base + W'(b);
            mem[p][tail[p]] = {(b == len - 1), d};
            tail[p]++;
        end
    endtask

    // Source and sink driver: AXIS-legal sources (valid held until handshake).
    initial begin
        logic [N-1:0] hs;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        forever begin
            @(negedge aclk);
            hs = s_axis_tvalid & s_axis_tready;
            @(posedge aclk);
            #1;
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) head[i]++;
                if (head[i] >= tail[i]) begin
                    s_axis_tvalid[i] = 1'b0;
                end else begin
                    if (hs[i] || !s_axis_tvalid[i])
                        s_axis_tvalid[i] = ($urandom_range(99) < vprob);
                    s_axis_tdata[i*W +: W] = mem[i][head[i]][W-1:0];
                    s_axis_tlast[i]        = mem[i][head[i]][W];
                end
            end
            case (rmode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ((cyc % 3) == 0);
                default: m_axis_tready = 1'($urandom_range(1));
            endcase
        end
    end

    // Packet-level reference: who owns the sink, and which beats must appear.
    initial begin
        int lastg;
        int rem;
        int exp_pkts;
        logic [N-1:0] req;
        logic [N-1:0] exp_rdy;
        logic exp_v;
        lastg = N - 1;
        rem = 0;
        exp_pkts = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                m_owner = -1;
                lastg = N - 1;
                rem = 0;
                exp_pkts = 0;
                sb.delete();
            end else begin
                exp_rdy = '0;
                exp_v = 1'b0;
                if (m_owner >= 0) begin
                    exp_rdy[m_owner] = m_axis_tready;
                    exp_v = s_axis_tvalid[m_owner];
                end
                chk("s_tready", 64'(s_axis_tready), 64'(exp_rdy));
                chk("m_tvalid", 64'(m_axis_tvalid), 64'(exp_v));
                chk("grant_valid", 64'(grant_valid), 64'(m_owner >= 0));
                if (m_owner >= 0) chk("grant_id", 64'(grant_id), 64'(m_owner));
                chk("pkt_count", 64'(pkt_count), 64'(exp_pkts));
                if (m_owner < 0) begin
                    req = s_axis_tvalid & port_en;
                    if (req != '0) begin
                        for (int k = 1; k <= N; k++) begin
                            int p;
                            p = (lastg + k) % N;
                            if (m_owner < 0 && req[p]) m_owner = p;
                        end
                        for (int idx = head[m_owner]; idx < tail[m_owner]; idx++) begin
                            exp_t e;
                            e.dat  = mem[m_owner][idx][W-1:0];
                            e.last = mem[m_owner][idx][W];
                            e.port = m_owner;
                            sb.push_back(e);
                            rem++;
                            if (e.last) break;
                        end
                    end
                end else if (s_axis_tvalid[m_owner] && m_axis_tready) begin
                    rem--;
                    if (rem == 0) begin
                        lastg = m_owner;
                        m_owner = -1;
                        exp_pkts++;
                    end
                end
            end
        end
    end

    // Monitor: every output handshake must match the next expected beat.
    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            if (aresetn && m_axis_tvalid && m_axis_tready) begin
                dut_beats++;
                if (sb.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_beat: got data 0x%0h from port %0d, expected no beat", m_axis_tdata, grant_id);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", {31'd0, m_axis_tlast, m_axis_tdata}, {31'd0, e.last, e.dat});
                    chk("beat_port", 64'(grant_id), 64'(e.port));
                end
                if (m_axis_tlast) dut_log.push_back(int'(grant_id));
            end
        end
    end

    task automatic flush();
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        dut_log.delete();
        dut_beats = 0;
    endtask

    task automatic do_reset();
        @(posedge aclk); #2;
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #2;
        flush();
        @(posedge aclk); #2;
        aresetn = 1'b1;
    endtask

    function automatic bit drained(input logic [N-1:0] mask);
        bit ok;
        ok = (m_owner < 0);
        for (int i = 0; i < N; i++)
            if (mask[i] && head[i] < tail[i]) ok = 0;
        return ok;
    endfunction

    task automatic wait_drain(input string name, input logic [N-1:0] mask);
        int n;
        n = 0;
        while (n < 5000 && !drained(mask)) begin
            @(posedge aclk); #2;
            n++;
        end
        tests_run++;
        if (!drained(mask)) begin
            tests_failed++;
            $display("FAIL %s_drain: timed out after %0d cycles, expected all packets delivered", name, n);
        end
    endtask

    task automatic wait_beats(input string name, input int nb);
        int n;
        n = 0;
        while (n < 1000 && dut_beats < nb) begin
            @(posedge aclk); #2;
            n++;
        end
        tests_run++;
        if (dut_beats < nb) begin
            tests_failed++;
            $display("FAIL %s_wait: saw %0d beats, expected at least %0d", name, dut_beats, nb);
        end
    endtask

    task automatic chk_log(input string name, input int exp_q[$]);
        chk({name, "_npkts"}, 64'(dut_log.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < dut_log.size(); i++)
            chk({name, "_order"}, 64'(dut_log[i]), 64'(exp_q[i]));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        int total;
        int zeros;
        port_en = '1;
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_grant_valid", 64'(grant_valid), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_tdata_known", 64'($isunknown({m_axis_tdata, m_axis_tlast})), 64'd0);
        #1 aresetn = 1'b1;

        // Single 3-beat packet on port 1.
        push_pkt(1, 3, 32'h11, 0);
        wait_drain("t1", '1);
        chk("t1_pkt_count", 64'(pkt_count), 64'd1);
        chk("t1_beats", 64'(dut_beats), 64'd3);
        chk_log("t1", '{1});

        // Ports 0 and 2 contend from reset.
        do_reset();
        push_pkt(0, 2, 32'h01, 0);
        push_pkt(2, 2, 32'h21, 0);
        wait_drain("t2", '1);
        chk("t2_pkt_count", 64'(pkt_count), 64'd2);
        chk_log("t2", '{0, 2});

        // All ports continuously valid with single-beat packets.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < N; p++)
                push_pkt(p, 1, 32'h40 + 32'(p * 16 + r), 0);
        wait_drain("t3", '1);
        chk("t3_pkt_count", 64'(pkt_count), 64'd8);
        chk_log("t3", '{0, 1, 2, 3, 0, 1, 2, 3});

        // Port 3 under a stuttering sink.
        do_reset();
        rmode = 1;
        push_pkt(3, 4, 32'h31, 0);
        wait_drain("t4", '1);
        chk("t4_beats", 64'(dut_beats), 64'd4);
        chk("t4_pkt_count", 64'(pkt_count), 64'd1);
        rmode = 0;

        // Port 0 masked; port 1 disabled mid-packet must still finish.
        do_reset();
        port_en = 4'b1110;
        push_pkt(0, 1, 32'h01, 0);
        push_pkt(1, 4, 32'h11, 0);
        push_pkt(2, 2, 32'h21, 0);
        push_pkt(3, 1, 32'h31, 0);
        wait_beats("t5", 1);
        port_en = 4'b1100;
        wait_drain("t5", 4'b1110);
        repeat (4) @(posedge aclk);
        chk("t5_pkt_count", 64'(pkt_count), 64'd3);
        chk_log("t5", '{1, 2, 3});
        zeros = 0;
        foreach (dut_log[i]) if (dut_log[i] == 0) zeros++;
        chk("t5_port0_grants", 64'(zeros), 64'd0);
        do_reset();
        port_en = '1;

        // Reset on the second beat of a 5-beat packet from port 2.
        push_pkt(2, 5, 32'h51, 0);
        wait_beats("t6", 1);
        aresetn = 1'b0;
        @(posedge aclk); #1;
        chk("t6_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("t6_s_tready", 64'(s_axis_tready), 64'd0);
        chk("t6_pkt_count", 64'(pkt_count), 64'd0);
        chk("t6_grant_valid", 64'(grant_valid), 64'd0);
        @(posedge aclk); #2;
        flush();
        @(posedge aclk); #2;
        aresetn = 1'b1;
        push_pkt(0, 1, 32'h61, 0);
        push_pkt(2, 1, 32'h62, 0);
        wait_drain("t6", '1);
        chk_log("t6", '{0, 2});

        // Randomized traffic: gaps, random sink stalls, random enable masks.
        do_reset();
        vprob = 60;
        rmode = 2;
        total = 0;
        for (int p = 0; p < N; p++)
            for (int k = 0; k < 30; k++) begin
                push_pkt(p, $urandom_range(1, 5), '0, 1);
                total++;
            end
        for (int n = 0; n < 20000 && !drained('1); n++) begin
            if (n % 64 == 0) port_en = (n < 3000) ? N'($urandom) : '1;
            @(posedge aclk); #2;
        end
        tests_run++;
        if (!drained('1)) begin
            tests_failed++;
            $display("FAIL t7_drain: traffic not delivered, expected all %0d packets", total);
        end
        repeat (4) @(posedge aclk);
        chk("t7_pkt_count", 64'(pkt_count), 64'(total));
        chk("t7_log_size", 64'(dut_log.size()), 64'(total));
        chk("t7_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
